// File: rtl/decoder_pkg.sv
// Shared ISA constants for the 16-bit decoder: opcodes, one-hot class
// bit positions and the decoded-field bundle.
package decoder_pkg;

  localparam int unsigned NUM_CLASSES = 26;

  typedef enum logic [3:0] {
    OP_ADI  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_NAND = 4'b0010,
    OP_LLI  = 4'b0011,
    OP_LW   = 4'b0100,
    OP_SW   = 4'b0101,
    OP_LM   = 4'b0110,
    OP_SM   = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_BLT  = 4'b1001,
    OP_BLE  = 4'b1010,
    OP_JAL  = 4'b1100,
    OP_JLR  = 4'b1101,
    OP_JRI  = 4'b1111
  } opcode_e;

  // Bit positions inside one_hot_o
  localparam logic [4:0] OH_ADA = 5'd0;
  localparam logic [4:0] OH_ADC = 5'd1;
  localparam logic [4:0] OH_ADZ = 5'd2;
  localparam logic [4:0] OH_AWC = 5'd3;
  localparam logic [4:0] OH_ACA = 5'd4;
  localparam logic [4:0] OH_ACC = 5'd5;
  localparam logic [4:0] OH_ACZ = 5'd6;
  localparam logic [4:0] OH_ACW = 5'd7;
  localparam logic [4:0] OH_ADI = 5'd8;
  localparam logic [4:0] OH_NDU = 5'd9;
  localparam logic [4:0] OH_NDC = 5'd10;
  localparam logic [4:0] OH_NDZ = 5'd11;
  localparam logic [4:0] OH_NCU = 5'd12;
  localparam logic [4:0] OH_NCC = 5'd13;
  localparam logic [4:0] OH_NCZ = 5'd14;
  localparam logic [4:0] OH_LLI = 5'd15;
  localparam logic [4:0] OH_LW  = 5'd16;
  localparam logic [4:0] OH_SW  = 5'd17;
  localparam logic [4:0] OH_LM  = 5'd18;
  localparam logic [4:0] OH_SM  = 5'd19;
  localparam logic [4:0] OH_BEQ = 5'd20;
  localparam logic [4:0] OH_BLT = 5'd21;
  localparam logic [4:0] OH_BLE = 5'd22;
  localparam logic [4:0] OH_JAL = 5'd23;
  localparam logic [4:0] OH_JLR = 5'd24;
  localparam logic [4:0] OH_JRI = 5'd25;

  typedef struct packed {
    logic [NUM_CLASSES-1:0] one_hot;
    logic [2:0]             rd;
    logic [2:0]             ra;
    logic [2:0]             rb;
    logic [15:0]            imm;
  } dec_fields_t;

  function automatic logic [NUM_CLASSES-1:0] class_bit(input logic [4:0] pos);
    return NUM_CLASSES'(1) << pos;
  endfunction

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational instruction decode: class one-hot, register
// indices and unscaled immediate. Illegal encodings decode to all zero.
module instr_field_decode
  import decoder_pkg::*;
(
  input  logic [15:0]            instr_i,
  output logic [NUM_CLASSES-1:0] one_hot_o,
  output logic [2:0]             rd_idx_o,
  output logic [2:0]             ra_idx_o,
  output logic [2:0]             rb_idx_o,
  output logic [15:0]            imm_val_o
);

  logic [2:0] f_ra;
  logic [2:0] f_rb;
  logic [2:0] f_rc;
  logic [2:0] f_cz;

  assign f_ra = instr_i[11:9];
  assign f_rb = instr_i[8:6];
  assign f_rc = instr_i[5:3];
  assign f_cz = instr_i[2:0];

  // Opcode-driven field extraction; unlisted fields stay zero.
  always_comb begin
    one_hot_o = '0;
    rd_idx_o  = '0;
    ra_idx_o  = '0;
    rb_idx_o  = '0;
    imm_val_o = '0;
    case (opcode_e'(instr_i[15:12]))
      OP_ADD: begin
        rd_idx_o = f_rc;
        ra_idx_o = f_ra;
        rb_idx_o = f_rb;
        case (f_cz)
          3'b000:  one_hot_o = class_bit(OH_ADA);
          3'b001:  one_hot_o = class_bit(OH_ADZ);
          3'b010:  one_hot_o = class_bit(OH_ADC);
          3'b011:  one_hot_o = class_bit(OH_AWC);
          3'b100:  one_hot_o = class_bit(OH_ACA);
          3'b101:  one_hot_o = class_bit(OH_ACZ);
          3'b110:  one_hot_o = class_bit(OH_ACC);
          default: one_hot_o = class_bit(OH_ACW);
        endcase
      end
      OP_NAND: begin
        if (f_cz[1:0] != 2'b11) begin
          rd_idx_o = f_rc;
          ra_idx_o = f_ra;
          rb_idx_o = f_rb;
          case (f_cz)
            3'b000:  one_hot_o = class_bit(OH_NDU);
            3'b001:  one_hot_o = class_bit(OH_NDZ);
            3'b010:  one_hot_o = class_bit(OH_NDC);
            3'b100:  one_hot_o = class_bit(OH_NCU);
            3'b101:  one_hot_o = class_bit(OH_NCZ);
            default: one_hot_o = class_bit(OH_NCC);
          endcase
        end
      end
      OP_ADI: begin
        one_hot_o = class_bit(OH_ADI);
        rd_idx_o  = f_rb;
        ra_idx_o  = f_ra;
        imm_val_o = sext6(instr_i[5:0]);
      end
      OP_LLI: begin
        one_hot_o = class_bit(OH_LLI);
        rd_idx_o  = f_ra;
        imm_val_o = {7'b0, instr_i[8:0]};
      end
      OP_LW: begin
        one_hot_o = class_bit(OH_LW);
        rd_idx_o  = f_ra;
        ra_idx_o  = f_rb;
        imm_val_o = sext6(instr_i[5:0]);
      end
      OP_SW: begin
        one_hot_o = class_bit(OH_SW);
        ra_idx_o  = f_rb;
        rb_idx_o  = f_ra;
        imm_val_o = sext6(instr_i[5:0]);
      end
      OP_LM, OP_SM: begin
        one_hot_o = (instr_i[12]) ? class_bit(OH_SM) : class_bit(OH_LM);
        ra_idx_o  = f_ra;
        imm_val_o = {8'b0, instr_i[7:0]};
      end
      OP_BEQ, OP_BLT, OP_BLE: begin
        case (instr_i[13:12])
          2'b00:   one_hot_o = class_bit(OH_BEQ);
          2'b01:   one_hot_o = class_bit(OH_BLT);
          default: one_hot_o = class_bit(OH_BLE);
        endcase
        ra_idx_o  = f_ra;
        rb_idx_o  = f_rb;
        imm_val_o = sext6(instr_i[5:0]);
      end
      OP_JAL: begin
        one_hot_o = class_bit(OH_JAL);
        rd_idx_o  = f_ra;
        imm_val_o = sext9(instr_i[8:0]);
      end
      OP_JLR: begin
        one_hot_o = class_bit(OH_JLR);
        rd_idx_o  = f_ra;
        ra_idx_o  = f_rb;
      end
      OP_JRI: begin
        one_hot_o = class_bit(OH_JRI);
        ra_idx_o  = f_ra;
        imm_val_o = sext9(instr_i[8:0]);
      end
      default: begin
        one_hot_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/decoder.sv
// Decode stage: fetch handshake plus the registered decode outputs.
// Field extraction lives in instr_field_decode.
module decoder
  import decoder_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   instr_valid_i,
  input  logic [15:0]            fetch_pc_i,
  input  logic [15:0]            fetch_instr_i,
  input  logic                   mem_stall_i,
  output logic                   fetch_valid_w,
  output logic                   opcode_valid_o,
  output logic [15:0]            opcode_pc_o,
  output logic [15:0]            opcode_instr_o,
  output logic [NUM_CLASSES-1:0] one_hot_o,
  output logic [2:0]             rd_idx_o,
  output logic [2:0]             ra_idx_o,
  output logic [2:0]             rb_idx_o,
  output logic [15:0]            imm_val_o
);

  dec_fields_t dec_w;
  logic        valid_q, valid_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  dec_fields_t fields_q, fields_d;

  instr_field_decode u_field_decode (
    .instr_i   (fetch_instr_i),
    .one_hot_o (dec_w.one_hot),
    .rd_idx_o  (dec_w.rd),
    .ra_idx_o  (dec_w.ra),
    .rb_idx_o  (dec_w.rb),
    .imm_val_o (dec_w.imm)
  );

  assign fetch_valid_w = rst_i & ~mem_stall_i;

  // Next state: capture on handshake, drop valid on an empty slot, hold on stall.
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    fields_d = fields_q;
    if (fetch_valid_w) begin
      if (instr_valid_i) begin
        valid_d  = 1'b1;
        pc_d     = fetch_pc_i;
        instr_d  = fetch_instr_i;
        fields_d = dec_w;
      end else begin
        valid_d  = 1'b0;
      end
    end
  end

  // Output registers; synchronous active-low reset takes priority.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      instr_q  <= '0;
      fields_q <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      fields_q <= fields_d;
    end
  end

  assign opcode_valid_o = valid_q;
  assign opcode_pc_o    = pc_q;
  assign opcode_instr_o = instr_q;
  assign one_hot_o      = fields_q.one_hot;
  assign rd_idx_o       = fields_q.rd;
  assign ra_idx_o       = fields_q.ra;
  assign rb_idx_o       = fields_q.rb;
  assign imm_val_o      = fields_q.imm;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed cases plus random traffic
// against a table-driven reference model.
module tb_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic [15:0] pc;
  logic [15:0] ins;
  logic        stall;
  logic        fvw;
  logic        ov;
  logic [15:0] opc;
  logic [15:0] oins;
  logic [25:0] oh;
  logic [2:0]  rd, ra, rb;
  logic [15:0] imm;

  always #5 clk = ~clk;

  decoder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_valid_i  (iv),
    .fetch_pc_i     (pc),
    .fetch_instr_i  (ins),
    .mem_stall_i    (stall),
    .fetch_valid_w  (fvw),
    .opcode_valid_o (ov),
    .opcode_pc_o    (opc),
    .opcode_instr_o (oins),
    .one_hot_o      (oh),
    .rd_idx_o       (rd),
    .ra_idx_o       (ra),
    .rb_idx_o       (rb),
    .imm_val_o      (imm)
  );

  typedef struct packed {
    logic [25:0] oh;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] imm;
  } ref_t;

  int checks   = 0;
  int failures = 0;

  // Class bit per [2:0] for the ADD and NAND groups; -1 marks illegal.
  int add_tbl[8]  = '{0, 2, 1, 3, 4, 6, 5, 7};
  int nand_tbl[8] = '{9, 11, 10, -1, 12, 14, 13, -1};

  logic        m_valid;
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  ref_t        m_dec;

  function automatic ref_t ref_dec(input logic [15:0] w);
    ref_t r;
    int op, fa, fb, fc, s6, s9, cls;
    op  = int'(w[15:12]);
    fa  = int'(w[11:9]);
    fb  = int'(w[8:6]);
    fc  = int'(w[5:3]);
    s6  = int'(w[5:0]); if (s6 >= 32)  s6 -= 64;
    s9  = int'(w[8:0]); if (s9 >= 256) s9 -= 512;
    r   = '0;
    cls = -1;
    case (op)
      0:  begin cls = 8;  r.rd = 3'(fb); r.ra = 3'(fa); r.imm = 16'(s6); end
      1:  begin cls = add_tbl[w[2:0]];
                r.rd = 3'(fc); r.ra = 3'(fa); r.rb = 3'(fb); end
      2:  begin cls = nand_tbl[w[2:0]];
                if (cls >= 0) begin r.rd = 3'(fc); r.ra = 3'(fa); r.rb = 3'(fb); end end
      3:  begin cls = 15; r.rd = 3'(fa); r.imm = 16'(int'(w[8:0])); end
      4:  begin cls = 16; r.rd = 3'(fa); r.ra = 3'(fb); r.imm = 16'(s6); end
      5:  begin cls = 17; r.ra = 3'(fb); r.rb = 3'(fa); r.imm = 16'(s6); end
      6, 7: begin cls = 12 + op; r.ra = 3'(fa); r.imm = 16'(int'(w[7:0])); end
      8, 9, 10: begin cls = 12 + op; r.ra = 3'(fa); r.rb = 3'(fb); r.imm = 16'(s6); end
      12: begin cls = 23; r.rd = 3'(fa); r.imm = 16'(s9); end
      13: begin cls = 24; r.rd = 3'(fa); r.ra = 3'(fb); end
      15: begin cls = 25; r.ra = 3'(fa); r.imm = 16'(s9); end
      default: cls = -1;
    endcase
    if (cls >= 0) r.oh = 26'(1) << cls;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic v,
                       input logic [15:0] p, input logic [15:0] w);
    rst = r; stall = s; iv = v; pc = p; ins = w;
  endtask

  // One clock: update the model from the inputs seen at the edge, then
  // compare every output shortly after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_valid = 1'b0; m_pc = '0; m_instr = '0; m_dec = '0;
    end else if (!stall) begin
      if (iv) begin
        m_valid = 1'b1; m_pc = pc; m_instr = ins; m_dec = ref_dec(ins);
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("valid", 32'(ov),   32'(m_valid));
    check("pc",    32'(opc),  32'(m_pc));
    check("instr", 32'(oins), 32'(m_instr));
    check("onehot",32'(oh),   32'(m_dec.oh));
    check("rd",    32'(rd),   32'(m_dec.rd));
    check("ra",    32'(ra),   32'(m_dec.ra));
    check("rb",    32'(rb),   32'(m_dec.rb));
    check("imm",   32'(imm),  32'(m_dec.imm));
    check("ohcnt", 32'($countones(oh) <= 1), 32'(1));
    check("fetch_valid", 32'(fvw), 32'(rst & ~stall));
  endtask

  initial begin
    logic [25:0] exp_oh;
    logic [15:0] frz_pc;
    m_valid = 1'b0; m_pc = '0; m_instr = '0; m_dec = '0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick(); tick();
    check("rst_valid", 32'(ov), 32'(0));

    // LLI example
    drive(1'b1, 1'b0, 1'b1, 16'h002A, 16'h3A01);
    tick();
    exp_oh = 26'(1) << 15;
    check("lli_oh",  32'(oh),  32'(exp_oh));
    check("lli_rd",  32'(rd),  32'(5));
    check("lli_imm", 32'(imm), 32'h0001);
    check("lli_pc",  32'(opc), 32'h002A);

    drive(1'b1, 1'b0, 1'b1, 16'h002B, 16'h4973);
    tick();
    check("lw_ra",  32'(ra),  32'(5));
    check("lw_imm", 32'(imm), 32'hFFF3);

    drive(1'b1, 1'b0, 1'b1, 16'h002C, 16'h570F);
    tick();
    check("sw_rb",  32'(rb),  32'(3));
    check("sw_ra",  32'(ra),  32'(4));

    drive(1'b1, 1'b0, 1'b1, 16'h002D, 16'hA281);
    tick();
    exp_oh = 26'(1) << 22;
    check("ble_oh", 32'(oh), 32'(exp_oh));

    drive(1'b1, 1'b0, 1'b1, 16'h002E, 16'h6472);
    tick();
    check("lm_imm", 32'(imm), 32'h0072);

    // Empty slot drops valid
    drive(1'b1, 1'b0, 1'b0, 16'h1111, 16'h0000);
    tick();
    check("empty_valid", 32'(ov), 32'(0));

    // NAND with illegal CZ
    drive(1'b1, 1'b0, 1'b1, 16'h0030, 16'h2FFB);
    tick();
    check("nand_ill_oh", 32'(oh), 32'(0));

    // Stall three cycles with instructions on offer
    drive(1'b1, 1'b0, 1'b1, 16'h0040, 16'h1A8A);
    tick();
    frz_pc = opc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 16'(16'h0050 + i), 16'hC123);
      tick();
      check("stall_fvw", 32'(fvw), 32'(0));
      check("stall_pc",  32'(opc), 32'(frz_pc));
    end
    drive(1'b1, 1'b0, 1'b1, 16'h0060, 16'hD2C0);
    tick();
    check("release_pc", 32'(opc), 32'h0060);

    // Illegal opcode, then reset while a capture and a stall are offered
    drive(1'b1, 1'b0, 1'b1, 16'h0070, 16'hB000);
    tick();
    check("ill_valid", 32'(ov),  32'(1));
    check("ill_oh",    32'(oh),  32'(0));
    check("ill_imm",   32'(imm), 32'(0));
    drive(1'b0, 1'b1, 1'b1, 16'h0071, 16'h3A01);
    tick();
    check("mid_rst_valid", 32'(ov),   32'(0));
    check("mid_rst_instr", 32'(oins), 32'(0));
    drive(1'b0, 1'b0, 1'b1, 16'h0072, 16'h3A01);
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 39) != 0),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) != 0),
            16'($urandom), 16'($urandom));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
